edge_trig_pipe: RTL and testbench

- Parametrised, multi-channel successor to the single-channel edge-triggered compare/add-subtract unit.
- Per channel, per cycle: if A > B then XOUT = A + B, else XOUT = A - B.
- Adds configurable width and channel count, signed and saturating modes, a 2-stage valid/ready pipeline with backpressure, per-channel status flags and a transfer counter.
- Sits between operand producers and result consumers in the datapath.

---
 rtl/edge_trig_pipe_pkg.sv | 12 +
 rtl/edge_trig_pipe_if.sv | 28 ++
 rtl/edge_trig_pipe_lane.sv | 41 ++++
 rtl/edge_trig_pipe.sv | 87 ++++++++
 tb/tb_edge_trig_pipe.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/edge_trig_pipe_pkg.sv
// Shared mode encoding for the edge-triggered compare/add-subtract pipeline.
package edge_trig_pkg;
    localparam int MODE_SAT = 0;
    localparam int MODE_SGN = 1;

    typedef enum logic [1:0] {
        UWRAP = 2'd0,
        USAT  = 2'd1,
        SWRAP = 2'd2,
        SSAT  = 2'd3
    } mode_e;
endpackage

// File: rtl/edge_trig_pipe_if.sv
// Operand/result bundle bus. The producer/consumer side is the master; the unit is the slave.
interface edge_trig_pipe_if #(
    parameter int NW   = 8,
    parameter int NCH  = 4,
    parameter int CNTW = 16
);
    logic [1:0]        MODE;
    logic              IN_VALID;
    logic              IN_READY;
    logic [NCH*NW-1:0] A;
    logic [NCH*NW-1:0] B;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [NCH*NW-1:0] XOUT;
    logic [NCH-1:0]    GT;
    logic [NCH-1:0]    OVF;
    logic [CNTW-1:0]   COUNT;

    modport master (
        output MODE, IN_VALID, A, B, OUT_READY,
        input  IN_READY, OUT_VALID, XOUT, GT, OVF, COUNT
    );

    modport slave (
        input  MODE, IN_VALID, A, B, OUT_READY,
        output IN_READY, OUT_VALID, XOUT, GT, OVF, COUNT
    );
endinterface

// File: rtl/edge_trig_pipe_lane.sv
// Single-channel compare, then add (A > B) or subtract, with wrap or clamp; purely combinational.
module edge_trig_lane
    import edge_trig_pkg::*;
#(
    parameter int NW = 8
) (
    input  logic [NW-1:0] a,
    input  logic [NW-1:0] b,
    input  mode_e         mode,
    output logic          gt,
    output logic [NW-1:0] res,
    output logic          ovf
);
    logic [1:0]  mbits;
    logic        sat;
    logic        sgn;
    logic [NW:0] ext_a;
    logic [NW:0] ext_b;
    logic [NW:0] raw;

    assign mbits = mode;

    always_comb begin
        sat   = mbits[MODE_SAT];
        sgn   = mbits[MODE_SGN];
        gt    = sgn ? ($signed(a) > $signed(b)) : (a > b);
        // One extra bit holds the exact result: zero-extended when unsigned, sign-extended when signed.
        ext_a = {sgn & a[NW-1], a};
        ext_b = {sgn & b[NW-1], b};
        raw   = gt ? (ext_a + ext_b) : (ext_a - ext_b);
        ovf   = sgn ? (raw[NW] ^ raw[NW-1]) : raw[NW];
        res   = raw[NW-1:0];
        if (sat && ovf) begin
            if (sgn) begin
                res = raw[NW] ? {1'b1, {(NW-1){1'b0}}} : {1'b0, {(NW-1){1'b1}}};
            end else begin
                res = gt ? '1 : '0;
            end
        end
    end
endmodule

// File: rtl/edge_trig_pipe.sv
// NCH-lane compare/add-subtract unit: 2-cycle latency, 1 bundle/cycle, holds up to 2 bundles
// under OUT_READY backpressure; bubbles collapse so an empty stage never blocks input.
module edge_trig_pipe
    import edge_trig_pkg::*;
#(
    parameter int NW   = 8,
    parameter int NCH  = 4,
    parameter int CNTW = 16
) (
    input  logic           CLK,
    input  logic           RST,
    edge_trig_pipe_if.slave bus
);
    logic              s1_valid;
    logic [NCH*NW-1:0] s1_a;
    logic [NCH*NW-1:0] s1_b;
    mode_e             s1_mode;

    logic              out_valid;
    logic [NCH*NW-1:0] xout_q;
    logic [NCH-1:0]    gt_q;
    logic [NCH-1:0]    ovf_q;
    logic [CNTW-1:0]   count_q;

    logic [NCH*NW-1:0] lane_res;
    logic [NCH-1:0]    lane_gt;
    logic [NCH-1:0]    lane_ovf;

    logic adv1;
    logic adv2;

    assign adv2 = !out_valid || bus.OUT_READY;
    assign adv1 = !s1_valid || adv2;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        edge_trig_lane #(.NW(NW)) u_lane (
            .a    (s1_a[k*NW +: NW]),
            .b    (s1_b[k*NW +: NW]),
            .mode (s1_mode),
            .gt   (lane_gt[k]),
            .res  (lane_res[k*NW +: NW]),
            .ovf  (lane_ovf[k])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_mode   <= UWRAP;
            out_valid <= 1'b0;
            xout_q    <= '0;
            gt_q      <= '0;
            ovf_q     <= '0;
            count_q   <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= bus.IN_VALID;
                if (bus.IN_VALID) begin
                    s1_a    <= bus.A;
                    s1_b    <= bus.B;
                    s1_mode <= mode_e'(bus.MODE);
                end
            end
            // Result registers only move when stage 2 advances, so a stalled result stays put.
            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    xout_q <= lane_res;
                    gt_q   <= lane_gt;
                    ovf_q  <= lane_ovf;
                end
            end
            if (out_valid && bus.OUT_READY) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign bus.IN_READY  = adv1 && !RST;
    assign bus.OUT_VALID = out_valid;
    assign bus.XOUT      = xout_q;
    assign bus.GT        = gt_q;
    assign bus.OVF       = ovf_q;
    assign bus.COUNT     = count_q;
endmodule

// File: tb/tb_edge_trig_pipe.sv
// Directed bench for edge_trig_pipe (NW=8, NCH=4, CNTW=3 so the counter wrap is reachable).
module tb_edge_trig_pipe;
    localparam int NW   = 8;
    localparam int NCH  = 4;
    localparam int CNTW = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks   = 0;
    int failures = 0;

    edge_trig_pipe_if #(.NW(NW), .NCH(NCH), .CNTW(CNTW)) bus ();

    edge_trig_pipe #(.NW(NW), .NCH(NCH), .CNTW(CNTW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic do_reset();
        RST = 1'b1;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Sends one bundle into an empty pipe and returns the first result presented.
    task automatic apply(input logic [1:0] m, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] x, output logic [3:0] g, output logic [3:0] o,
                         output logic ok);
        int n;
        bus.MODE = m; bus.A = av; bus.B = bv;
        bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        n = 0;
        while (!bus.OUT_VALID && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        ok = bus.OUT_VALID;
        x  = bus.XOUT; g = bus.GT; o = bus.OVF;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
        bus.MODE = 2'd0; bus.A = 32'h0; bus.B = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", bus.OUT_VALID); end
        checks++; if (bus.XOUT !== 32'h0) begin failures++; $display("FAIL rst_xout got=%h want=0", bus.XOUT); end
        checks++; if (bus.GT !== 4'h0 || bus.OVF !== 4'h0) begin failures++; $display("FAIL rst_flags gt=%b ovf=%b want=0", bus.GT, bus.OVF); end
        checks++; if (bus.COUNT !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d want=0", bus.COUNT); end
        checks++; if (bus.IN_READY !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b want=0", bus.IN_READY); end
        RST = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.A = {8'd0, 8'd0, 8'd5, 8'd200};
        bus.B = {8'd0, 8'd0, 8'd9, 8'd100};
        #1;
        checks++; if (bus.IN_READY !== 1'b1) begin failures++; $display("FAIL in_ready_after_rst got=%b want=1", bus.IN_READY); end
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        checks++; if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL latency_early got=%b want=0", bus.OUT_VALID); end
        @(posedge CLK); #1;
        checks++; if (bus.OUT_VALID !== 1'b1) begin failures++; $display("FAIL latency_2 got=%b want=1", bus.OUT_VALID); end
        checks++; if (bus.XOUT[15:0] !== {8'd252, 8'd44}) begin failures++; $display("FAIL latency_xout got=%h want=fc2c", bus.XOUT[15:0]); end
        checks++; if (bus.GT[1:0] !== 2'b01 || bus.OVF[1:0] !== 2'b11) begin failures++; $display("FAIL latency_flags gt=%b ovf=%b want gt=01 ovf=11", bus.GT[1:0], bus.OVF[1:0]); end
        @(posedge CLK); #1;
    endtask

    task automatic test_modes();
        logic [31:0] x; logic [3:0] g, o; logic ok;
        // ch0 200,100 / ch1 5,9 / ch2 7,7 (equality) / ch3 255,0 (exact add)
        apply(2'd0, {8'd255, 8'd7, 8'd5, 8'd200}, {8'd0, 8'd7, 8'd9, 8'd100}, x, g, o, ok);
        checks++; if (!ok || x !== {8'd255, 8'd0, 8'd252, 8'd44} || g !== 4'b1001 || o !== 4'b0011) begin
            failures++; $display("FAIL uwrap ok=%b x=%h gt=%b ovf=%b want x=ff00fc2c gt=1001 ovf=0011", ok, x, g, o); end
        apply(2'd1, {8'd9, 8'd9, 8'd5, 8'd200}, {8'd9, 8'd5, 8'd9, 8'd100}, x, g, o, ok);
        checks++; if (!ok || x !== {8'd0, 8'd14, 8'd0, 8'd255} || g !== 4'b0101 || o !== 4'b0011) begin
            failures++; $display("FAIL usat ok=%b x=%h gt=%b ovf=%b want x=000e00ff gt=0101 ovf=0011", ok, x, g, o); end
        apply(2'd3, {8'h01, 8'hFF, 8'h80, 8'h64}, {8'hFF, 8'h01, 8'h01, 8'h50}, x, g, o, ok);
        checks++; if (!ok || x !== 32'h00FE807F || g !== 4'b1001 || o !== 4'b0011) begin
            failures++; $display("FAIL ssat ok=%b x=%h gt=%b ovf=%b want x=00fe807f gt=1001 ovf=0011", ok, x, g, o); end
        apply(2'd2, {8'h10, 8'h7F, 8'h64, 8'h80}, {8'h20, 8'h80, 8'h50, 8'h01}, x, g, o, ok);
        checks++; if (!ok || x !== 32'hF0FFB47F || g !== 4'b0110 || o !== 4'b0011) begin
            failures++; $display("FAIL swrap ok=%b x=%h gt=%b ovf=%b want x=f0ffb47f gt=0110 ovf=0011", ok, x, g, o); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, c = 0;
        logic [7:0] v;
        logic [31:0] held;
        do_reset();
        bus.MODE = 2'd0; bus.B = 32'h0;
        while (got < 6 && c < 60) begin
            @(posedge CLK); #1;
            bus.OUT_READY = !(c >= 3 && c <= 7);
            bus.IN_VALID  = (sent < 6);
            v = 8'(sent + 1);
            bus.A = {4{v}};
            #1;
            if (c == 3) held = bus.XOUT;
            if (c == 5) begin
                checks++; if (bus.IN_READY !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b want=0", bus.IN_READY); end
            end
            if (c == 7) begin
                checks++; if (bus.OUT_VALID !== 1'b1 || bus.XOUT !== held) begin
                    failures++; $display("FAIL bp_held vld=%b x=%h want vld=1 x=%h", bus.OUT_VALID, bus.XOUT, held); end
            end
            if (bus.IN_VALID && bus.IN_READY) sent++;
            if (bus.OUT_VALID && bus.OUT_READY) begin
                v = 8'(got + 1);
                checks++; if (bus.XOUT !== {4{v}} || bus.GT !== 4'hF || bus.OVF !== 4'h0) begin
                    failures++; $display("FAIL bp_order idx=%0d x=%h gt=%b ovf=%b want x=%h gt=1111 ovf=0000", got, bus.XOUT, bus.GT, bus.OVF, {4{v}}); end
                got++;
            end
            c++;
        end
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        checks++; if (got !== 6) begin failures++; $display("FAIL bp_delivered got=%0d want=6", got); end
        checks++; if (bus.COUNT !== 3'd6) begin failures++; $display("FAIL bp_count got=%0d want=6", bus.COUNT); end
        @(posedge CLK); #1;
        checks++; if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b want=0", bus.OUT_VALID); end
    endtask

    task automatic test_flush();
        logic seen = 1'b0;
        do_reset();
        bus.MODE = 2'd0; bus.A = 32'h11223344; bus.B = 32'h0;
        bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b0;
        @(posedge CLK); #1;
        checks++; if (bus.IN_READY !== 1'b1) begin failures++; $display("FAIL fill_one got=%b want=1", bus.IN_READY); end
        @(posedge CLK); #1;
        checks++; if (bus.IN_READY !== 1'b0 || bus.OUT_VALID !== 1'b1) begin
            failures++; $display("FAIL fill_two rdy=%b vld=%b want rdy=0 vld=1", bus.IN_READY, bus.OUT_VALID); end
        RST = 1'b1; bus.OUT_READY = 1'b1; bus.IN_VALID = 1'b0;
        @(posedge CLK); #1;
        checks++; if (bus.OUT_VALID !== 1'b0 || bus.COUNT !== 3'd0) begin
            failures++; $display("FAIL flush_rst vld=%b count=%0d want vld=0 count=0", bus.OUT_VALID, bus.COUNT); end
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            if (bus.OUT_VALID) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_leak got=%b want=0", seen); end
    endtask

    task automatic test_count_wrap();
        int sent = 0, got = 0, c = 0;
        do_reset();
        bus.MODE = 2'd0; bus.B = 32'h0; bus.OUT_READY = 1'b1;
        while (got < 9 && c < 60) begin
            @(posedge CLK); #1;
            bus.IN_VALID = (sent < 9);
            bus.A = 32'(sent);
            #1;
            if (bus.IN_VALID && bus.IN_READY) sent++;
            if (bus.OUT_VALID && bus.OUT_READY) got++;
            c++;
        end
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        checks++; if (got !== 9 || bus.COUNT !== 3'd1) begin
            failures++; $display("FAIL count_wrap got=%0d count=%0d want got=9 count=1", got, bus.COUNT); end
    endtask

    initial begin
        bus.MODE = 2'd0; bus.A = '0; bus.B = '0;
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
        test_reset();
        test_modes();
        test_back_to_back();
        test_flush();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
